instr_buffer_reader: RTL and testbench

- Read-side sequencer for the instruction buffer.
- Waits for the buffer's start indication, walks buffer indices 0..BS-1 through the buffer's registered read port, and issues each non-zero instruction downstream on a valid/ready handshake.
- Stops at the first all-zero word (end marker) or after BS entries, then pulses done.
- Sits between the instruction buffer and the execution/decode stage.

---
 rtl/instr_buffer_reader_if.sv | 28 ++
 rtl/instr_buffer_reader.sv | 128 ++++++++++++
 tb/tb_instr_buffer_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_buffer_reader_if.sv
// Handshake and buffer-port bundle between the instruction buffer, the reader and the decode stage.
// The master modport is the reader's side of the bundle.
interface instr_buffer_reader_if #(
   parameter int INSTR_W = 32,
   parameter int BS      = 16
);
   localparam int IW = $clog2(BS);

   logic               start;
   logic [IW-1:0]      rd_index;
   logic [INSTR_W-1:0] rd_data;
   logic [INSTR_W-1:0] out_instr;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic               done;
   logic [IW:0]        issued_count;

   modport master (
      input  start, rd_data, out_ready,
      output rd_index, out_instr, out_valid, busy, done, issued_count
   );

   modport slave (
      output start, rd_data, out_ready,
      input  rd_index, out_instr, out_valid, busy, done, issued_count
   );
endinterface

// File: rtl/instr_buffer_reader.sv
// Read-side sequencer: walks the instruction buffer through its registered read port and issues
// each non-zero word downstream on valid/ready, stopping at an all-zero end marker or after BS entries.
//
// state   | meaning
// IDLE    | waiting for a rising edge on start
// FETCH   | rd_index presented to the buffer's registered read port
// LOAD    | rd_data valid; end marker check
// ISSUE   | out_valid held until downstream accepts
// DONE    | one-cycle done pulse, then back to IDLE
module instr_buffer_reader #(
   parameter int INSTR_W = 32,
   parameter int BS      = 16
) (
   input logic                   clk,
   input logic                   rst,
   instr_buffer_reader_if.master bus
);
   localparam int IW = $clog2(BS);
   localparam int CW = IW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_ISSUE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      rd_index_q, rd_index_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CW-1:0]      issued_count_q, issued_count_d;
   logic               start_q;
   logic               trigger;

   assign trigger = bus.start && !start_q;

   always_comb begin
      state_d        = state_q;
      rd_index_d     = rd_index_q;
      out_instr_d    = out_instr_q;
      out_valid_d    = out_valid_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      issued_count_d = issued_count_q;

      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d        = S_FETCH;
               rd_index_d     = '0;
               busy_d         = 1'b1;
               issued_count_d = '0;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            if (bus.rd_data == '0) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               rd_index_d  = '0;
               out_valid_d = 1'b0;
            end else begin
               state_d     = S_ISSUE;
               out_instr_d = bus.rd_data;
               out_valid_d = 1'b1;
            end
         end
         S_ISSUE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d    = 1'b0;
               issued_count_d = issued_count_q + CW'(1);
               // Last index ends the pass here, so rd_index never wraps.
               if (rd_index_q == IW'(BS - 1)) begin
                  state_d    = S_DONE;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  rd_index_d = '0;
               end else begin
                  state_d    = S_FETCH;
                  rd_index_d = rd_index_q + IW'(1);
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d     = S_IDLE;
            rd_index_d  = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // start_q resets high so a start already asserted out of reset is not seen as an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         rd_index_q     <= '0;
         out_instr_q    <= '0;
         out_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         issued_count_q <= '0;
         start_q        <= 1'b1;
      end else begin
         state_q        <= state_d;
         rd_index_q     <= rd_index_d;
         out_instr_q    <= out_instr_d;
         out_valid_q    <= out_valid_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         issued_count_q <= issued_count_d;
         start_q        <= bus.start;
      end
   end

   assign bus.rd_index     = rd_index_q;
   assign bus.out_instr    = out_instr_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.issued_count = issued_count_q;
endmodule

// File: tb/tb_instr_buffer_reader.sv
// Bench for instr_buffer_reader: registered-read buffer model, handshake monitor and a
// reference that derives the expected issue stream straight from the buffer contents.
module tb_instr_buffer_reader;
   localparam int INSTR_W = 32;
   localparam int BS      = 16;
   localparam int IW      = $clog2(BS);
   localparam int CW      = IW + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instr_buffer_reader_if #(.INSTR_W(INSTR_W), .BS(BS)) bus ();

   instr_buffer_reader #(.INSTR_W(INSTR_W), .BS(BS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic [INSTR_W-1:0] mem [BS];
   always @(posedge clk) bus.rd_data <= mem[bus.rd_index];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   logic [INSTR_W-1:0] obs_q [$];
   int                 obs_cyc [$];
   logic [INSTR_W-1:0] exp_q [$];
   int                 done_cnt = 0;
   logic               pend = 1'b0;
   logic [INSTR_W-1:0] pend_instr = '0;

   // Handshake monitor: what is seen at the falling edge is what the next rising edge acts on.
   always @(negedge clk) begin
      if (pend) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== pend_instr) begin
            errors++;
            $display("FAIL hold_under_backpressure: valid=%b instr=%h, required valid=1 instr=%h",
                     bus.out_valid, bus.out_instr, pend_instr);
         end
      end
      pend       = rst && bus.out_valid && !bus.out_ready;
      pend_instr = bus.out_instr;
      if (rst && bus.out_valid && bus.out_ready) begin
         obs_q.push_back(bus.out_instr);
         obs_cyc.push_back(cyc);
      end
      if (bus.done === 1'b1) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected stream: buffer entries in index order up to (not including) the first zero word.
   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i < BS; i++) begin
         if (mem[i] == '0) break;
         exp_q.push_back(mem[i]);
      end
   endtask

   task automatic fill_random(input int zero_at);
      logic [INSTR_W-1:0] v;
      for (int i = 0; i < BS; i++) begin
         v = INSTR_W'($urandom);
         if (v == '0) v = 1;
         mem[i] = v;
      end
      if (zero_at < BS) mem[zero_at] = '0;
   endtask

   task automatic start_pass();
      obs_q.delete();
      obs_cyc.delete();
      done_cnt  = 0;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1;
   endtask

   task automatic wait_done(input int budget, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      rst           = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (bus.rd_index !== '0) begin errors++; $display("FAIL reset_rd_index: got %0h, required 0", bus.rd_index); end
      if (bus.out_instr !== '0) begin errors++; $display("FAIL reset_out_instr: got %0h, required 0", bus.out_instr); end
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
      if (bus.issued_count !== '0) begin errors++; $display("FAIL reset_issued_count: got %0d, required 0", bus.issued_count); end
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks += 2;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release_no_pass: busy=%b valid=%b, required 0 0", bus.busy, bus.out_valid);
      end
      if (done_cnt != 0) begin errors++; $display("FAIL reset_release_done: got %0d pulses, required 0", done_cnt); end
   endtask

   task automatic test_full_pass();
      bit ok;
      for (int i = 0; i < BS; i++) mem[i] = INSTR_W'(32'h11 + i);
      build_expected();
      bus.out_ready = 1'b1;
      start_pass();
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL full_busy_rise: got %b, required 1", bus.busy); end
      wait_done(200, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_timeout: done not seen, required within 200 cycles"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL full_issue_count: got %0d issues, required %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_data[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
         end
         for (int i = 1; i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
               errors++; $display("FAIL full_interval[%0d]: got %0d cycles, required 3", i, obs_cyc[i] - obs_cyc[i-1]);
            end
         end
      end
      checks += 4;
      if (bus.issued_count !== CW'(BS)) begin errors++; $display("FAIL full_issued_count: got %0d, required %0d", bus.issued_count, BS); end
      if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulse: got %0d cycles, required 1", done_cnt); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_fall: got %b, required 0", bus.busy); end
      if (bus.rd_index !== '0) begin errors++; $display("FAIL full_rd_index: got %0d, required 0", bus.rd_index); end
   endtask

   task automatic test_end_marker();
      bit ok;
      fill_random(5);
      build_expected();
      start_pass();
      wait_done(200, 1'b0, ok);
      checks += 4;
      if (!ok) begin errors++; $display("FAIL marker_timeout: done not seen, required within 200 cycles"); end
      if (obs_q.size() != 5) begin errors++; $display("FAIL marker_issue_count: got %0d, required 5", obs_q.size()); end
      if (bus.issued_count !== CW'(5)) begin errors++; $display("FAIL marker_issued_count: got %0d, required 5", bus.issued_count); end
      if (done_cnt != 1) begin errors++; $display("FAIL marker_done_pulse: got %0d, required 1", done_cnt); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL marker_data[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit found;
      fill_random(BS);
      build_expected();
      bus.out_ready = 1'b1;
      start_pass();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 && bus.issued_count === CW'(2)) begin
            found = 1'b1;
            break;
         end
      end
      bus.out_ready = 1'b0;
      checks += 2;
      if (!found) begin errors++; $display("FAIL bp_reach_index2: ISSUE of index 2 not seen within 100 cycles"); end
      if (bus.out_instr !== mem[2]) begin errors++; $display("FAIL bp_instr: got %h, required %h", bus.out_instr, mem[2]); end
      repeat (4) begin
         @(posedge clk); #1;
         checks += 3;
         if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b, required 1", bus.out_valid); end
         if (bus.out_instr !== mem[2]) begin errors++; $display("FAIL bp_instr_held: got %h, required %h", bus.out_instr, mem[2]); end
         if (bus.issued_count !== CW'(2)) begin errors++; $display("FAIL bp_count_held: got %0d, required 2", bus.issued_count); end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checks += 3;
      if (bus.issued_count !== CW'(3)) begin errors++; $display("FAIL bp_accept_count: got %0d, required 3", bus.issued_count); end
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_valid: got %b, required 0", bus.out_valid); end
      if (bus.rd_index !== IW'(3)) begin errors++; $display("FAIL bp_next_index: got %0d, required 3", bus.rd_index); end
      wait_done(200, 1'b0, ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen, required within 200 cycles"); end
      if (obs_q != exp_q) begin errors++; $display("FAIL bp_stream: got %0d issues, required %0d matching entries", obs_q.size(), exp_q.size()); end
      if (bus.issued_count !== CW'(BS)) begin errors++; $display("FAIL bp_issued_count: got %0d, required %0d", bus.issued_count, BS); end
   endtask

   task automatic test_start_retrigger();
      int  done_at;
      logic busy_seen;
      obs_q.delete();
      done_cnt = 0;
      repeat (10) @(posedge clk);
      #1;
      checks += 2;
      if (bus.busy !== 1'b0 || obs_q.size() != 0) begin
         errors++; $display("FAIL retrig_held_start: busy=%b issues=%0d, required 0 0", bus.busy, obs_q.size());
      end
      if (done_cnt != 0) begin errors++; $display("FAIL retrig_held_done: got %0d, required 0", done_cnt); end
      fill_random(0);
      start_pass();
      done_at   = -1;
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 0) busy_seen = bus.busy;
         if (bus.done === 1'b1) begin
            done_at = i;
            break;
         end
      end
      checks += 4;
      if (busy_seen !== 1'b1) begin errors++; $display("FAIL retrig_busy: got %b, required 1", busy_seen); end
      if (done_at != 2) begin errors++; $display("FAIL retrig_done_latency: got %0d, required 2", done_at); end
      if (bus.issued_count !== '0) begin errors++; $display("FAIL retrig_issued_count: got %0d, required 0", bus.issued_count); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL retrig_busy_fall: got %b, required 0", bus.busy); end
      @(posedge clk); #1;
      checks += 2;
      if (done_cnt != 1) begin errors++; $display("FAIL retrig_done_pulse: got %0d, required 1", done_cnt); end
      if (obs_q.size() != 0) begin errors++; $display("FAIL retrig_no_issue: got %0d, required 0", obs_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit found;
      fill_random(BS);
      bus.out_ready = 1'b1;
      start_pass();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 && bus.issued_count === CW'(7)) begin
            found = 1'b1;
            break;
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks += 6;
      if (!found) begin errors++; $display("FAIL rstmid_reach_index7: ISSUE of index 7 not seen within 100 cycles"); end
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", bus.busy); end
      if (bus.rd_index !== '0) begin errors++; $display("FAIL rstmid_rd_index: got %0d, required 0", bus.rd_index); end
      if (bus.issued_count !== '0) begin errors++; $display("FAIL rstmid_issued_count: got %0d, required 0", bus.issued_count); end
      if (bus.out_instr !== '0) begin errors++; $display("FAIL rstmid_out_instr: got %h, required 0", bus.out_instr); end
      rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks += 3;
      if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_cnt); end
      if (obs_q.size() != 7) begin errors++; $display("FAIL rstmid_issues: got %0d, required 7", obs_q.size()); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_restart: busy=%b, required 0", bus.busy); end
   endtask

   task automatic test_random();
      bit ok;
      int zero_at;
      for (int it = 0; it < 8; it++) begin
         zero_at = $urandom_range(0, BS);
         fill_random(zero_at);
         build_expected();
         start_pass();
         wait_done(800, 1'b1, ok);
         checks += 4;
         if (!ok) begin errors++; $display("FAIL rand%0d_timeout: done not seen, required within 800 cycles", it); end
         if (obs_q != exp_q) begin
            errors++; $display("FAIL rand%0d_stream: got %0d issues, required %0d matching entries", it, obs_q.size(), exp_q.size());
         end
         if (bus.issued_count !== CW'(exp_q.size())) begin
            errors++; $display("FAIL rand%0d_issued_count: got %0d, required %0d", it, bus.issued_count, exp_q.size());
         end
         if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_pulse: got %0d, required 1", it, done_cnt); end
      end
   endtask

   initial begin
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < BS; i++) mem[i] = '0;
      test_reset();
      test_full_pass();
      test_end_marker();
      test_backpressure();
      test_start_retrigger();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
